dm_verdict_aggregator: RTL and testbench

Parametrised decision module for the firewall rule pipeline. It collects per-rule match/accept results from LANES parallel rule-matching units over RULES/LANES beats and produces one packet verdict. Two decision modes are supported: all-rules-accept AND, and first-match with default policy. It reports the deciding rule index and holds the verdict under a ready/valid handshake toward the packet forwarding stage.

---
 rtl/dm_verdict_aggregator_if.sv | 33 +++
 rtl/dm_verdict_aggregator.sv | 173 +++++++++++++++++
 tb/tb_dm_verdict_aggregator.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_verdict_aggregator_if.sv
// Verdict aggregator bus: rule-result beats in, packet verdict out.
//   master : upstream/downstream side (drives beats and out_ready)
//   slave  : aggregator side (drives ready, status and verdict fields)
interface dm_verdict_aggregator_if #(
  parameter int unsigned LANES = 2,
  parameter int unsigned IW    = 8
);
  logic             ena;
  logic             start;
  logic [LANES-1:0] match_in;
  logic [LANES-1:0] accept_in;
  logic             default_accept;
  logic             out_ready;
  logic             in_ready;
  logic             busy;
  logic             verdict_valid;
  logic             verdict_accept;
  logic             verdict_hit;
  logic [IW-1:0]    verdict_rule;
  logic             aborted;

  modport master (
    output ena, start, match_in, accept_in, default_accept, out_ready,
    input  in_ready, busy, verdict_valid, verdict_accept, verdict_hit,
           verdict_rule, aborted
  );

  modport slave (
    input  ena, start, match_in, accept_in, default_accept, out_ready,
    output in_ready, busy, verdict_valid, verdict_accept, verdict_hit,
           verdict_rule, aborted
  );
endinterface

// File: rtl/dm_verdict_aggregator.sv
// Firewall packet verdict aggregator: folds LANES rule results per beat over
// RULES/LANES beats into one verdict (MODE 0: AND of accepts, MODE 1:
// first match with default policy) and holds it under ready/valid.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of dm_verdict_aggregator_if (beats in, verdict out)
module dm_verdict_aggregator #(
  parameter int unsigned LANES = 2,
  parameter int unsigned RULES = 256,
  parameter int unsigned MODE  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dm_verdict_aggregator_if.slave bus
);

  localparam int unsigned BEATS = RULES / LANES;
  localparam int unsigned IW    = (RULES > 1) ? $clog2(RULES) : 1;
  localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned CW    = $clog2(BEATS + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           acc_hit_q, acc_hit_d;
  logic [IW-1:0]  acc_rule_q, acc_rule_d;
  logic           acc_sel_q, acc_sel_d;
  logic           valid_q, valid_d;
  logic           accept_q, accept_d;
  logic           hit_q, hit_d;
  logic [IW-1:0]  rule_q, rule_d;
  logic           aborted_q, aborted_d;
  logic           in_ready_q, in_ready_d;
  logic           busy_q, busy_d;

  logic [LANES-1:0] decide_c;
  logic             beat_hit_c;
  logic [LW-1:0]    lane_c;
  logic             lane_accept_c;
  logic             do_load_c;
  logic             do_fold_c;
  logic [IW-1:0]    beat_rule_c;

  // Per-beat deciding lane: a reject in MODE 0, a match in MODE 1; lowest lane wins
  always_comb begin
    decide_c   = (MODE == 0) ? ~bus.accept_in : bus.match_in;
    beat_hit_c = |decide_c;
    lane_c     = '0;
    for (int k = int'(LANES) - 1; k >= 0; k--) begin
      if (decide_c[k]) lane_c = LW'(k);
    end
    lane_accept_c = bus.accept_in[lane_c];
  end

  // Next-state, accumulator and verdict logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_hit_d  = acc_hit_q;
    acc_rule_d = acc_rule_q;
    acc_sel_d  = acc_sel_q;
    valid_d    = valid_q;
    accept_d   = accept_q;
    hit_d      = hit_q;
    rule_d     = rule_q;
    aborted_d  = 1'b0;
    do_load_c  = 1'b0;
    do_fold_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.ena && bus.start) do_load_c = 1'b1;
      end
      COLLECT: begin
        if (bus.ena) begin
          if (bus.start) begin
            do_load_c = 1'b1;
            aborted_d = 1'b1;
          end else begin
            do_fold_c = 1'b1;
          end
        end
      end
      DONE: begin
        // Handshake cycle frees the verdict and may also accept a start beat
        if (bus.out_ready) begin
          state_d  = IDLE;
          valid_d  = 1'b0;
          accept_d = 1'b0;
          hit_d    = 1'b0;
          rule_d   = '0;
          if (bus.ena && bus.start) do_load_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Rule index of this beat's deciding lane; a start beat is beat 0
    beat_rule_c = do_load_c ? IW'(lane_c)
                            : IW'(32'(cnt_q) * LANES + 32'(lane_c));

    if (do_load_c) begin
      state_d    = COLLECT;
      cnt_d      = CW'(1);
      acc_hit_d  = beat_hit_c;
      acc_rule_d = beat_rule_c;
      acc_sel_d  = lane_accept_c;
    end

    if (do_fold_c) begin
      cnt_d = cnt_q + CW'(1);
      // Only the first deciding rule is kept
      if (!acc_hit_q && beat_hit_c) begin
        acc_hit_d  = 1'b1;
        acc_rule_d = beat_rule_c;
        acc_sel_d  = lane_accept_c;
      end
    end

    if ((do_load_c || do_fold_c) && (cnt_d == CW'(BEATS))) begin
      state_d  = DONE;
      valid_d  = 1'b1;
      hit_d    = acc_hit_d;
      rule_d   = acc_hit_d ? acc_rule_d : '0;
      accept_d = (MODE == 0) ? !acc_hit_d
                             : (acc_hit_d ? acc_sel_d : bus.default_accept);
    end

    in_ready_d = (state_d != DONE);
    busy_d     = (state_d == COLLECT);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_hit_q  <= 1'b0;
      acc_rule_q <= '0;
      acc_sel_q  <= 1'b0;
      valid_q    <= 1'b0;
      accept_q   <= 1'b0;
      hit_q      <= 1'b0;
      rule_q     <= '0;
      aborted_q  <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_hit_q  <= acc_hit_d;
      acc_rule_q <= acc_rule_d;
      acc_sel_q  <= acc_sel_d;
      valid_q    <= valid_d;
      accept_q   <= accept_d;
      hit_q      <= hit_d;
      rule_q     <= rule_d;
      aborted_q  <= aborted_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.busy           = busy_q;
  assign bus.verdict_valid  = valid_q;
  assign bus.verdict_accept = accept_q;
  assign bus.verdict_hit    = hit_q;
  assign bus.verdict_rule   = rule_q;
  assign bus.aborted        = aborted_q;

endmodule

// File: tb/tb_dm_verdict_aggregator.sv
// Bench for dm_verdict_aggregator: three configurations (MODE 0 / MODE 1 with
// LANES=2 RULES=256, MODE 0 with LANES=4 RULES=4) sharing one stimulus path,
// checked every cycle against a rule-list reference model.
module tb_dm_verdict_aggregator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       ena, start, dflt, out_ready;
  logic [3:0] match, accept;
  int         sel;

  dm_verdict_aggregator_if #(.LANES(2), .IW(8)) ifa ();
  dm_verdict_aggregator_if #(.LANES(2), .IW(8)) ifb ();
  dm_verdict_aggregator_if #(.LANES(4), .IW(2)) ifc ();

  assign ifa.ena = ena && (sel == 0);
  assign ifa.start = start;
  assign ifa.match_in = match[1:0];
  assign ifa.accept_in = accept[1:0];
  assign ifa.default_accept = dflt;
  assign ifa.out_ready = out_ready;

  assign ifb.ena = ena && (sel == 1);
  assign ifb.start = start;
  assign ifb.match_in = match[1:0];
  assign ifb.accept_in = accept[1:0];
  assign ifb.default_accept = dflt;
  assign ifb.out_ready = out_ready;

  assign ifc.ena = ena && (sel == 2);
  assign ifc.start = start;
  assign ifc.match_in = match;
  assign ifc.accept_in = accept;
  assign ifc.default_accept = dflt;
  assign ifc.out_ready = out_ready;

  dm_verdict_aggregator #(.LANES(2), .RULES(256), .MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  dm_verdict_aggregator #(.LANES(2), .RULES(256), .MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  dm_verdict_aggregator #(.LANES(4), .RULES(4), .MODE(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  logic       dv, dacc, dhit, dab, dinr, dbusy;
  logic [7:0] drule;

  always_comb begin
    case (sel)
      0: begin
        dv = ifa.verdict_valid; dacc = ifa.verdict_accept; dhit = ifa.verdict_hit;
        drule = ifa.verdict_rule; dab = ifa.aborted; dinr = ifa.in_ready; dbusy = ifa.busy;
      end
      1: begin
        dv = ifb.verdict_valid; dacc = ifb.verdict_accept; dhit = ifb.verdict_hit;
        drule = ifb.verdict_rule; dab = ifb.aborted; dinr = ifb.in_ready; dbusy = ifb.busy;
      end
      default: begin
        dv = ifc.verdict_valid; dacc = ifc.verdict_accept; dhit = ifc.verdict_hit;
        drule = 8'(ifc.verdict_rule); dab = ifc.aborted; dinr = ifc.in_ready; dbusy = ifc.busy;
      end
    endcase
  end

  int total, bad, cyc, t_start;
  int cur_lanes, cur_beats, cur_mode;
  bit rand_or;

  // Reference model: per-rule results of the packet being collected
  bit r_acc[256];
  bit r_mat[256];
  int m_cnt;
  bit m_valid, m_acc, m_hit, m_ab, m_inr, m_busy;
  int m_rule;

  bit [3:0] pm[128];
  bit [3:0] pa[128];
  bit       st_at[128];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Verdict straight from the rule list: first deciding rule wins
  task automatic eval_verdict();
    m_hit  = 1'b0;
    m_rule = 0;
    m_acc  = (cur_mode == 0) ? 1'b1 : dflt;
    for (int i = 0; i < cur_beats * cur_lanes; i++) begin
      if (cur_mode == 0 && !r_acc[i]) begin
        m_hit = 1'b1; m_rule = i; m_acc = 1'b0; break;
      end
      if (cur_mode == 1 && r_mat[i]) begin
        m_hit = 1'b1; m_rule = i; m_acc = r_acc[i]; break;
      end
    end
  endtask

  task automatic store_beat();
    for (int k = 0; k < cur_lanes; k++) begin
      r_acc[m_cnt * cur_lanes + k] = accept[k];
      r_mat[m_cnt * cur_lanes + k] = match[k];
    end
    m_cnt++;
  endtask

  // Advance the model by one clock using the inputs about to be sampled
  task automatic model_update();
    bit take;
    if (!rst_n) begin
      m_cnt = 0; m_valid = 0; m_acc = 0; m_hit = 0; m_rule = 0;
      m_ab = 0; m_inr = 0; m_busy = 0;
      return;
    end
    m_ab = 0;
    take = ena && (!m_valid || out_ready);
    if (m_valid && out_ready) begin
      m_valid = 0; m_acc = 0; m_hit = 0; m_rule = 0;
    end
    if (take && start) begin
      if (m_cnt > 0) m_ab = 1;
      m_cnt = 0;
      store_beat();
    end else if (take && m_cnt > 0) begin
      store_beat();
    end
    if (m_cnt == cur_beats) begin
      eval_verdict();
      m_valid = 1;
      m_cnt   = 0;
    end
    m_inr  = !m_valid;
    m_busy = (m_cnt > 0);
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    check("valid", 32'(dv), 32'(m_valid));
    check("accept", 32'(dacc), 32'(m_acc));
    check("hit", 32'(dhit), 32'(m_hit));
    check("rule", 32'(drule), m_rule);
    check("aborted", 32'(dab), 32'(m_ab));
    check("in_ready", 32'(dinr), 32'(m_inr));
    check("busy", 32'(dbusy), 32'(m_busy));
    if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Beats first..first+n-1 from pm/pa; stall_pct<0 uses the st_at table
  task automatic send(input int first, input int n, input int stall_pct);
    for (int b = first; b < first + n; b++) begin
      int guard;
      guard = 0;
      if (stall_pct < 0 && st_at[b]) begin
        ena = 0; step();
      end
      while ((stall_pct > 0 && $urandom_range(0, 99) < stall_pct) || (m_valid && !out_ready)) begin
        ena = 0; step(); guard++;
        if (guard > 2000) begin
          check("ready_wait", 0, 1);
          return;
        end
      end
      ena = 1; start = (b == 0); match = pm[b]; accept = pa[b];
      if (b == 0) t_start = cyc;
      step();
    end
    ena = 0; start = 0;
  endtask

  task automatic wait_valid();
    int g;
    g = 0;
    ena = 0;
    while (!dv && g < 400) begin
      step(); g++;
    end
    check("valid_seen", 32'(dv), 1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    rand_or = 0; out_ready = 1; ena = 0;
    while ((dv || m_valid) && g < 50) begin
      step(); g++;
    end
    step();
  endtask

  task automatic fill(input bit [3:0] a, input bit [3:0] m);
    for (int b = 0; b < 128; b++) begin
      pa[b] = a; pm[b] = m; st_at[b] = 0;
    end
  endtask

  task automatic gen_rand(input int sparse);
    for (int b = 0; b < cur_beats; b++) begin
      pa[b] = 4'($urandom);
      pm[b] = 4'h0;
      if (cur_mode == 0) begin
        pa[b] = 4'hF;
        if ($urandom_range(0, sparse) == 0) pa[b][$urandom_range(0, cur_lanes - 1)] = 1'b0;
      end else if ($urandom_range(0, sparse) == 0) begin
        pm[b] = 4'($urandom);
      end
    end
  endtask

  task automatic configure(input int s, input int lanes, input int beats, input int mode);
    sel = s; cur_lanes = lanes; cur_beats = beats; cur_mode = mode;
    ena = 0; start = 0; out_ready = 1; rand_or = 0;
    rst_n = 0; step(); step();
    rst_n = 1; step();
    check("rst_in_ready", 32'(dinr), 1);
    check("rst_valid", 32'(dv), 0);
  endtask

  task automatic random_packets(input int n);
    rand_or = 1;
    for (int p = 0; p < n; p++) begin
      dflt = 1'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        gen_rand(40);
        send(0, $urandom_range(1, cur_beats), 10);
      end
      gen_rand(40);
      send(0, cur_beats, 10);
    end
    rand_or = 0;
    out_ready = 1;
    wait_valid();
    drain();
  endtask

  initial begin
    rst_n = 0; ena = 0; start = 0; match = 0; accept = 0; dflt = 0;
    out_ready = 1; rand_or = 0; sel = 0;
    total = 0; bad = 0; cyc = 0; t_start = 0;

    // MODE 0, 2 lanes, 256 rules
    configure(0, 2, 128, 0);

    fill(4'hF, 4'h0);
    send(0, 128, 0);
    wait_valid();
    check("all_acc_latency", cyc - t_start, 128);
    check("all_acc_accept", 32'(dacc), 1);
    check("all_acc_hit", 32'(dhit), 0);
    check("all_acc_rule", 32'(drule), 0);
    step();
    check("all_acc_one_cycle", 32'(dv), 0);

    fill(4'hF, 4'h0);
    pa[38] = 4'hD;
    pa[100] = 4'hE;
    send(0, 128, 0);
    wait_valid();
    check("rej_accept", 32'(dacc), 0);
    check("rej_hit", 32'(dhit), 1);
    check("rej_rule", 32'(drule), 77);
    drain();

    fill(4'hF, 4'h0);
    for (int c = 0; c < 10; ) begin
      int p;
      p = $urandom_range(1, 127);
      if (!st_at[p]) begin
        st_at[p] = 1; c++;
      end
    end
    send(0, 128, -1);
    wait_valid();
    check("stall_latency", cyc - t_start, 138);
    drain();

    gen_rand(40);
    out_ready = 0;
    send(0, 128, 0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_in_ready", 32'(dinr), 0);
    end
    fill(4'hF, 4'h0);
    pa[3] = 4'hE;
    out_ready = 1;
    send(0, 1, 0);
    check("hs_start_busy", 32'(dbusy), 1);
    send(1, 127, 0);
    wait_valid();
    check("hs_second_rule", 32'(drule), 6);
    check("hs_second_accept", 32'(dacc), 0);
    drain();

    fill(4'hF, 4'h0);
    pa[5] = 4'hE;
    send(0, 40, 0);
    fill(4'hF, 4'h0);
    send(0, 1, 0);
    check("restart_aborted", 32'(dab), 1);
    send(1, 127, 0);
    wait_valid();
    check("restart_latency", cyc - t_start, 128);
    check("restart_accept", 32'(dacc), 1);
    check("restart_hit", 32'(dhit), 0);
    drain();

    send(0, 60, 0);
    rst_n = 0; step();
    rst_n = 1;
    check("midrst_busy", 32'(dbusy), 0);
    check("midrst_valid", 32'(dv), 0);
    step();

    random_packets(5);

    // MODE 1, 2 lanes, 256 rules
    configure(1, 2, 128, 1);

    fill(4'h3, 4'h0);
    pm[5] = 4'h3;
    pa[5] = 4'h2;
    dflt = 1;
    send(0, 128, 0);
    wait_valid();
    check("fm_accept", 32'(dacc), 0);
    check("fm_hit", 32'(dhit), 1);
    check("fm_rule", 32'(drule), 10);
    drain();

    fill(4'h0, 4'h0);
    dflt = 1;
    send(0, 128, 0);
    wait_valid();
    check("dflt_accept", 32'(dacc), 1);
    check("dflt_hit", 32'(dhit), 0);
    check("dflt_rule", 32'(drule), 0);
    drain();

    random_packets(6);

    // MODE 0, 4 lanes, 4 rules: one beat per packet
    configure(2, 4, 1, 0);

    pa[0] = 4'hB;
    pm[0] = 4'h0;
    send(0, 1, 0);
    check("b1_valid_next", 32'(dv), 1);
    check("b1_rule", 32'(drule), 2);
    check("b1_accept", 32'(dacc), 0);
    drain();

    out_ready = 1;
    for (int p = 0; p < 20; p++) begin
      gen_rand(2);
      send(0, 1, 0);
    end
    drain();

    rand_or = 1;
    for (int p = 0; p < 30; p++) begin
      gen_rand(2);
      send(0, 1, 20);
    end
    rand_or = 0;
    out_ready = 1;
    wait_valid();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
